// File: rtl/boot_loader_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg : shared definitions for the boot loader controller.
//   - boot_state_e : loader state encoding
//   - ACK/ERR byte defaults, default base address and image size limit
//   - IMEM_WE_ALL  : full-word instruction-memory write enable
//   - csum_add     : modulo-256 running sum used by the optional checksum
// No ports (package).
// -----------------------------------------------------------------------------
package boot_pkg;

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_ACK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } boot_state_e;

    localparam logic [7:0]  ACK_BYTE_DEF  = 8'hAA;
    localparam logic [7:0]  ERR_BYTE_DEF  = 8'hEE;
    localparam logic [31:0] BASE_ADDR_DEF = 32'h0000_0000;
    localparam int          MAX_WORDS_DEF = 4096;
    localparam logic [3:0]  IMEM_WE_ALL   = 4'hF;

    // 8-bit sum; the carry out is intentionally dropped (modulo 256).
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        csum_add = sum + data;
    endfunction

    // Byte address of word number idx; wraps modulo 2^32 by construction.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        word_addr = base + {idx[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// -----------------------------------------------------------------------------
// boot_loader_ctrl_if : bundles the UART byte streams and the instruction
// memory write port seen by the boot loader.
//   rx_data/rx_valid/rx_ready : byte stream from the UART receiver
//   tx_data/tx_valid/tx_ready : byte stream to the UART transmitter
//   imem_we/imem_addr/imem_wdata : instruction-memory write port
// Modports:
//   master : the loader (consumes rx, produces tx, drives imem)
//   slave  : the surrounding system (UART + instruction memory)
// -----------------------------------------------------------------------------
interface boot_loader_ctrl_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [3:0]  imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/boot_loader_ctrl_byte_assembler.sv
// -----------------------------------------------------------------------------
// byte_assembler : collects four bytes little-endian into one 32-bit word.
//   clk, rst       : clock, synchronous active-high reset
//   i_byte_valid   : a byte is being consumed this cycle
//   i_byte         : the byte being consumed
//   o_word         : assembled word (valid together with o_word_valid)
//   o_word_valid   : pulses in the cycle the 4th byte is consumed
// The first byte of a group lands in o_word[7:0]. The completed word is
// presented combinationally alongside the 4th byte so the owner can register
// it in the same edge that consumes that byte.
// -----------------------------------------------------------------------------
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_valid
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    // Byte counter and shift register of the three earlier bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_byte_valid) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end else begin
            r_cnt   <= r_cnt;
            r_shift <= r_shift;
        end
    end

    assign o_word       = {i_byte, r_shift};
    assign o_word_valid = i_byte_valid && (r_cnt == 2'd3);

endmodule

// File: rtl/boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// boot_loader_ctrl : receives a program image over the UART byte stream,
// writes it into instruction memory and then releases the core from reset.
// Stream format: 32-bit little-endian word count, then the words themselves
// (little-endian bytes). Replies ACK_BYTE on success, ERR_BYTE on error.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : boot_loader_ctrl_if.master (rx/tx byte streams, imem port)
//   core_rstn  : active-low core reset, released once the image is loaded
//   busy       : load in progress
//   done       : load complete, core running
//   err        : load failed (sticky until rst)
//
// Optional feature (macro BOOT_LOADER_CHECKSUM_EN): one extra byte after the
// image must equal the modulo-256 sum of all data bytes, otherwise ERR.
// -----------------------------------------------------------------------------
module boot_loader_ctrl
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF,
    parameter int          MAX_WORDS = MAX_WORDS_DEF,
    parameter logic [7:0]  ACK_BYTE  = ACK_BYTE_DEF,
    parameter logic [7:0]  ERR_BYTE  = ERR_BYTE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    boot_loader_ctrl_if.master  bus,
    output logic                core_rstn,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int          WIDX        = $clog2(MAX_WORDS + 1);
    localparam logic [31:0] MAX_WORDS_U = 32'(MAX_WORDS);

    boot_state_e       r_state;
    logic [WIDX-1:0]   r_len;
    logic [WIDX-1:0]   r_word_idx;
    logic              r_rx_ready;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic [3:0]        r_imem_we;
    logic [31:0]       r_imem_addr;
    logic [31:0]       r_imem_wdata;
    logic              r_core_rstn;
    logic              r_busy;
    logic              r_done;
    logic              r_err;

    logic              w_rx_fire;
    logic              w_tx_fire;
    logic              w_asm_in;
    logic [31:0]       w_word;
    logic              w_word_valid;
    logic [WIDX-1:0]   w_next_idx;
    logic              w_last;

    assign w_rx_fire  = bus.rx_valid && r_rx_ready;
    assign w_tx_fire  = r_tx_valid && bus.tx_ready;
    // Only the header and the image words go through the assembler.
    assign w_asm_in   = w_rx_fire && ((r_state == ST_LEN) || (r_state == ST_DATA));
    assign w_next_idx = r_word_idx + {{(WIDX-1){1'b0}}, 1'b1};
    assign w_last     = (w_next_idx == r_len);

    byte_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_byte_valid (w_asm_in),
        .i_byte       (bus.rx_data),
        .o_word       (w_word),
        .o_word_valid (w_word_valid)
    );

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;

    // Running sum of image data bytes; cleared while waiting for the header.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_LEN)) begin
            r_sum <= 8'd0;
        end else if (w_rx_fire && (r_state == ST_DATA)) begin
            r_sum <= csum_add(r_sum, bus.rx_data);
        end else begin
            r_sum <= r_sum;
        end
    end
`endif

    // Loader state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_LEN;
            r_len        <= '0;
            r_word_idx   <= '0;
            r_rx_ready   <= 1'b0;
            r_tx_data    <= 8'd0;
            r_tx_valid   <= 1'b0;
            r_imem_we    <= 4'h0;
            r_imem_addr  <= BASE_ADDR;
            r_imem_wdata <= 32'd0;
            r_core_rstn  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Write enable is a single-cycle pulse, only raised on entry to WRITE.
            r_imem_we <= 4'h0;
            case (r_state)
                ST_LEN: begin
                    r_rx_ready <= 1'b1;
                    r_busy     <= 1'b1;
                    if (w_word_valid) begin
                        r_len <= w_word[WIDX-1:0];
                        if (w_word == 32'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                            r_state    <= ST_CSUM;
`else
                            r_state    <= ST_ACK;
                            r_rx_ready <= 1'b0;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= ACK_BYTE;
`endif
                        end else if (w_word > MAX_WORDS_U) begin
                            r_state    <= ST_ERR;
                            r_rx_ready <= 1'b0;
                            r_busy     <= 1'b0;
                            r_err      <= 1'b1;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= ERR_BYTE;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_word_valid) begin
                        r_state      <= ST_WRITE;
                        r_rx_ready   <= 1'b0;
                        r_imem_we    <= IMEM_WE_ALL;
                        r_imem_addr  <= word_addr(BASE_ADDR, 32'(r_word_idx));
                        r_imem_wdata <= w_word;
                    end
                end
                ST_WRITE: begin
                    r_word_idx <= w_next_idx;
                    if (w_last) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                        r_state    <= ST_CSUM;
                        r_rx_ready <= 1'b1;
`else
                        r_state    <= ST_ACK;
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= ACK_BYTE;
`endif
                    end else begin
                        r_state    <= ST_DATA;
                        r_rx_ready <= 1'b1;
                    end
                end
                ST_CSUM: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                    if (w_rx_fire) begin
                        r_rx_ready <= 1'b0;
                        r_tx_valid <= 1'b1;
                        if (bus.rx_data == r_sum) begin
                            r_state   <= ST_ACK;
                            r_tx_data <= ACK_BYTE;
                        end else begin
                            r_state   <= ST_ERR;
                            r_busy    <= 1'b0;
                            r_err     <= 1'b1;
                            r_tx_data <= ERR_BYTE;
                        end
                    end
`else
                    // Unreachable without the checksum option: fail safe.
                    r_state    <= ST_ERR;
                    r_rx_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_err      <= 1'b1;
                    r_core_rstn <= 1'b0;
                    r_tx_valid <= 1'b1;
                    r_tx_data  <= ERR_BYTE;
`endif
                end
                ST_ACK: begin
                    // Core leaves reset in the same edge that completes the ack.
                    if (w_tx_fire) begin
                        r_state     <= ST_DONE;
                        r_tx_valid  <= 1'b0;
                        r_core_rstn <= 1'b1;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_rx_ready  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                ST_ERR: begin
                    // Error byte goes out exactly once; err stays set until rst.
                    if (w_tx_fire) begin
                        r_tx_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ERR;
                    r_rx_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_err       <= 1'b1;
                    r_core_rstn <= 1'b0;
                    r_tx_valid  <= 1'b1;
                    r_tx_data   <= ERR_BYTE;
                end
            endcase
        end
    end

    assign bus.rx_ready   = r_rx_ready;
    assign bus.tx_data    = r_tx_data;
    assign bus.tx_valid   = r_tx_valid;
    assign bus.imem_we    = r_imem_we;
    assign bus.imem_addr  = r_imem_addr;
    assign bus.imem_wdata = r_imem_wdata;
    assign core_rstn      = r_core_rstn;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// -----------------------------------------------------------------------------
// tb_boot_loader_ctrl : table-driven bench for boot_loader_ctrl plus
// hand-written sequences for reset values, ack back-pressure, mid-load reset
// and (when BOOT_LOADER_CHECKSUM_EN is defined) checksum match/mismatch.
// -----------------------------------------------------------------------------
module tb_boot_loader_ctrl;
    import boot_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic core_rstn, busy, done, err;

    always #5 clk = ~clk;

    boot_loader_ctrl_if bus ();

    boot_loader_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .core_rstn (core_rstn),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] len;
        logic [63:0] dat;      // byte i in dat[8*i +: 8]
        int          nbytes;
        int          nwr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [7:0]  exp_tx;
        logic        exp_err;
    } vec_t;

    wr_t        wr_q[$];
    int         tx_cnt;
    logic [7:0] tx_last;
    int         n_chk  = 0;
    int         n_fail = 0;

    // Monitor: records write pulses and accepted tx bytes between clock edges.
    always begin
        @(negedge clk);
        #2;
        if (bus.imem_we !== 4'h0) wr_q.push_back({bus.imem_we, bus.imem_addr, bus.imem_wdata});
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            tx_cnt  = tx_cnt + 1;
            tx_last = bus.tx_data;
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"},   {31'd0, bus.rx_ready}, 32'd0);
        chk({tag, "_tx_valid"},   {31'd0, bus.tx_valid}, 32'd0);
        chk({tag, "_tx_data"},    {24'd0, bus.tx_data},  32'd0);
        chk({tag, "_imem_we"},    {28'd0, bus.imem_we},  32'd0);
        chk({tag, "_imem_addr"},  bus.imem_addr,         32'h0000_0000);
        chk({tag, "_imem_wdata"}, bus.imem_wdata,        32'd0);
        chk({tag, "_core_rstn"},  {31'd0, core_rstn},    32'd0);
        chk({tag, "_busy"},       {31'd0, busy},         32'd0);
        chk({tag, "_done"},       {31'd0, done},         32'd0);
        chk({tag, "_err"},        {31'd0, err},          32'd0);
    endtask

    task automatic do_reset(input bit check, input string tag);
        @(negedge clk);
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        @(negedge clk);
        if (check) chk_reset_vals(tag);
        @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
        tx_cnt  = 0;
        tx_last = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t = t + 1;
        end
        if (t >= 50) chk("rx_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_stream();
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int t = 0;
        while (done !== 1'b1 && err !== 1'b1 && t < 200) begin
            @(negedge clk);
            t = t + 1;
        end
        if (t >= 200) chk({tag, "_end_timeout"}, 32'd0, 32'd1);
    endtask

    // Sends header and data; in the checksum build also the bench-computed sum.
    task automatic load(input logic [31:0] len, input logic [63:0] dat,
                        input int nbytes, input bit send_sum);
        logic [7:0] sum = 8'd0;
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8]);
        for (int i = 0; i < nbytes; i++) begin
            send_byte(dat[8*i +: 8]);
            sum = sum + dat[8*i +: 8];
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (send_sum) send_byte(sum);
`else
        if (send_sum) sum = 8'd0;
`endif
        end_stream();
    endtask

    vec_t tbl [5];

    initial begin
        bool_init();
    end

    task automatic bool_init();
        int bad_rx, bad_rstn, bad_tx, bad_data;
        string nm;

        tbl[0] = '{len: 32'd2, dat: 64'h8877_6655_4433_2211, nbytes: 8, nwr: 2,
                   w0: 32'h4433_2211, w1: 32'h8877_6655, exp_tx: 8'hAA, exp_err: 1'b0};
        tbl[1] = '{len: 32'd0, dat: 64'h0, nbytes: 0, nwr: 0,
                   w0: 32'h0, w1: 32'h0, exp_tx: 8'hAA, exp_err: 1'b0};
        tbl[2] = '{len: 32'd1, dat: 64'h0000_0000_EFBE_ADDE, nbytes: 4, nwr: 1,
                   w0: 32'hEFBE_ADDE, w1: 32'h0, exp_tx: 8'hAA, exp_err: 1'b0};
        tbl[3] = '{len: 32'd4097, dat: 64'h0, nbytes: 0, nwr: 0,
                   w0: 32'h0, w1: 32'h0, exp_tx: 8'hEE, exp_err: 1'b1};
        tbl[4] = '{len: 32'd2, dat: 64'h0123_4567_89AB_CDEF, nbytes: 8, nwr: 2,
                   w0: 32'h89AB_CDEF, w1: 32'h0123_4567, exp_tx: 8'hAA, exp_err: 1'b0};

        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.tx_ready = 1'b1;
        tx_cnt       = 0;
        tx_last      = 8'd0;

        // Reset state.
        do_reset(1'b1, "rst0");

        // Table-driven loads.
        for (int r = 0; r < 5; r++) begin
            nm = $sformatf("row%0d", r);
            if (r != 0) do_reset(1'b0, nm);
            load(tbl[r].len, tbl[r].dat, tbl[r].nbytes, !tbl[r].exp_err);
            wait_end(nm);
            bad_rx = 0; bad_rstn = 0; bad_tx = 0;
            for (int c = 0; c < 100; c++) begin
                @(negedge clk);
                if (bus.rx_ready !== 1'b0) bad_rx++;
                if (core_rstn !== !tbl[r].exp_err) bad_rstn++;
                if (bus.tx_valid !== 1'b0) bad_tx++;
            end
            chk({nm, "_wr_count"}, 32'(wr_q.size()), 32'(tbl[r].nwr));
            if (tbl[r].nwr >= 1 && wr_q.size() >= 1) begin
                chk({nm, "_wr0_we"},   {28'd0, wr_q[0].we}, 32'hF);
                chk({nm, "_wr0_addr"}, wr_q[0].addr, 32'h0000_0000);
                chk({nm, "_wr0_data"}, wr_q[0].data, tbl[r].w0);
            end
            if (tbl[r].nwr >= 2 && wr_q.size() >= 2) begin
                chk({nm, "_wr1_we"},   {28'd0, wr_q[1].we}, 32'hF);
                chk({nm, "_wr1_addr"}, wr_q[1].addr, 32'h0000_0004);
                chk({nm, "_wr1_data"}, wr_q[1].data, tbl[r].w1);
            end
            chk({nm, "_tx_count"},   32'(tx_cnt), 32'd1);
            chk({nm, "_tx_byte"},    {24'd0, tx_last}, {24'd0, tbl[r].exp_tx});
            chk({nm, "_err"},        {31'd0, err}, {31'd0, tbl[r].exp_err});
            chk({nm, "_done"},       {31'd0, done}, {31'd0, !tbl[r].exp_err});
            chk({nm, "_busy"},       {31'd0, busy}, 32'd0);
            chk({nm, "_rx_ready_hold"},  32'(bad_rx), 32'd0);
            chk({nm, "_core_rstn_hold"}, 32'(bad_rstn), 32'd0);
            chk({nm, "_tx_valid_hold"},  32'(bad_tx), 32'd0);
        end

        // Ack back-pressure: tx_ready low for 20 cycles.
        do_reset(1'b0, "stall");
        bus.tx_ready = 1'b0;
        load(32'd1, 64'h0000_0000_D4C3_B2A1, 4, 1'b1);
        begin
            int t = 0;
            while (bus.tx_valid !== 1'b1 && t < 100) begin
                @(negedge clk);
                t = t + 1;
            end
            if (t >= 100) chk("stall_tx_valid_timeout", 32'd0, 32'd1);
        end
        bad_tx = 0; bad_data = 0; bad_rstn = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.tx_valid !== 1'b1) bad_tx++;
            if (bus.tx_data !== 8'hAA) bad_data++;
            if (core_rstn !== 1'b0 || done !== 1'b0) bad_rstn++;
        end
        chk("stall_tx_valid_stable", 32'(bad_tx), 32'd0);
        chk("stall_tx_data_stable",  32'(bad_data), 32'd0);
        chk("stall_core_in_reset",   32'(bad_rstn), 32'd0);
        chk("stall_busy", {31'd0, busy}, 32'd1);
        bus.tx_ready = 1'b1;
        @(negedge clk);
        chk("stall_core_rstn_after", {31'd0, core_rstn}, 32'd1);
        chk("stall_done_after",      {31'd0, done}, 32'd1);
        chk("stall_tx_valid_after",  {31'd0, bus.tx_valid}, 32'd0);
        chk("stall_wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() >= 1) chk("stall_wr_data", wr_q[0].data, 32'hD4C3_B2A1);

        // Reset in the middle of the data phase, then a fresh one-word load.
        do_reset(1'b0, "midrst");
        for (int i = 0; i < 4; i++) send_byte(8'(i == 0 ? 2 : 0));
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        do_reset(1'b1, "midrst_rv");
        load(32'd1, 64'h0000_0000_8D7C_6B5A, 4, 1'b1);
        wait_end("reload");
        repeat (3) @(negedge clk);
        chk("reload_wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() >= 1) begin
            chk("reload_wr_addr", wr_q[0].addr, 32'h0000_0000);
            chk("reload_wr_data", wr_q[0].data, 32'h8D7C_6B5A);
        end
        chk("reload_tx_byte",   {24'd0, tx_last}, 32'h0000_00AA);
        chk("reload_done",      {31'd0, done}, 32'd1);
        chk("reload_core_rstn", {31'd0, core_rstn}, 32'd1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Checksum match: 01+02+03+04 = 0x0A is wrong on purpose? No: sum is 0x0A.
        do_reset(1'b0, "csum_ok");
        load(32'd1, 64'h0000_0000_0403_0201, 4, 1'b0);
        send_byte(8'h0A);
        end_stream();
        wait_end("csum_ok");
        repeat (3) @(negedge clk);
        chk("csum_ok_tx", {24'd0, tx_last}, 32'h0000_00AA);
        chk("csum_ok_done", {31'd0, done}, 32'd1);
        do_reset(1'b0, "csum_bad");
        load(32'd1, 64'h0000_0000_0403_0201, 4, 1'b0);
        send_byte(8'h0C);
        end_stream();
        wait_end("csum_bad");
        repeat (3) @(negedge clk);
        chk("csum_bad_tx",  {24'd0, tx_last}, 32'h0000_00EE);
        chk("csum_bad_err", {31'd0, err}, 32'd1);
        chk("csum_bad_core_rstn", {31'd0, core_rstn}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

endmodule
